rd_burst_arb: RTL and testbench

Read-side burst arbiter for the asynchronous FIFO, in the `rclk` domain. It shares the single FIFO read port (`rempty`/`rinc`/`rdata`) among `NUM_REQ` consumers using round-robin arbitration. Each grant drains a burst of up to `BURST_LEN` words through one valid/ready output channel. Bursts end early, reported on status pulses, if the requester withdraws or the FIFO stays empty too long.

---
 rtl/rd_burst_arb.sv | 135 +++++++++++++
 tb/tb_rd_burst_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_arb.sv
// rd_burst_arb: read-side burst arbiter for the async FIFO (rclk domain).
// Shares the single FIFO read port among NUM_REQ consumers round-robin.
// Each grant drains up to BURST_LEN words through a valid/ready channel.
// A burst ends early if the owner drops its request or the FIFO stays
// empty for TIMEOUT consecutive cycles.
module rd_burst_arb #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 rempty,
    input  logic [DATA_SIZE-1:0] rdata,
    output logic                 rinc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_last,
    output logic                 burst_done,
    output logic                 burst_abort,
    output logic                 burst_timeout
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int EMPTY_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(BURST_LEN - 1);
    localparam logic [EMPTY_W-1:0] EMPTY_MAX = EMPTY_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   pick;
    logic               pick_ok;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [EMPTY_W-1:0] empty_cnt;
    logic               req_held;
    logic               end_done;
    logic               end_drop;
    logic               end_tmo;
    logic               end_any;

    // The FIFO head word goes straight to the consumer.
    assign out_data = rdata;

    // Round-robin pick: first asserted request searching upward from last+1.
    // Scanning from the far end down lets the nearest candidate win.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = last;
        pick_ok = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (req[idx]) begin
                pick    = IDX_W'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge rclk) begin
        if (!rrst_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // FSM next-state: leave IDLE on any request, leave BURST on any exit.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_ok) state_nxt = S_BURST;
            S_BURST: if (end_any) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: beat handshake and exit conditions. A dropped request
    // suppresses the beat, so it outranks out_last. No pops while in reset.
    always_comb begin
        req_held  = (state == S_BURST) && req[gidx] && rrst_n;
        out_valid = req_held && !rempty;
        rinc      = out_valid && out_ready;
        out_last  = out_valid && (beat_cnt == BEAT_MAX);
        end_done  = rinc && out_last;
        end_drop  = (state == S_BURST) && !req[gidx];
        end_tmo   = req_held && rempty && (empty_cnt == EMPTY_MAX);
        end_any   = end_done || end_drop || end_tmo;
    end

    // Grant, round-robin pointer, burst counters and status pulses.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            grant         <= '0;
            gidx          <= '0;
            last          <= LAST_RST;
            beat_cnt      <= '0;
            empty_cnt     <= '0;
            burst_done    <= 1'b0;
            burst_abort   <= 1'b0;
            burst_timeout <= 1'b0;
        end else begin
            burst_done    <= 1'b0;
            burst_abort   <= 1'b0;
            burst_timeout <= 1'b0;
            if (state == S_IDLE) begin
                if (pick_ok) begin
                    grant     <= NUM_REQ'(1) << pick;
                    gidx      <= pick;
                    beat_cnt  <= '0;
                    empty_cnt <= '0;
                end
            end else if (end_any) begin
                grant         <= '0;
                last          <= gidx;
                burst_done    <= end_done;
                burst_abort   <= end_drop || end_tmo;
                burst_timeout <= end_tmo && !end_drop;
            end else begin
                if (rinc) beat_cnt <= beat_cnt + 1'b1;
                if (!rempty)                     empty_cnt <= '0;
                else if (empty_cnt != EMPTY_MAX) empty_cnt <= empty_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rd_burst_arb.sv
// tb_rd_burst_arb: directed scenarios plus randomized traffic for
// rd_burst_arb, checked every cycle against a behavioural arbiter model
// and a queue-based FIFO model, with literal expectations per scenario.
`timescale 1ns/1ps
module tb_rd_burst_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rrst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          burst_done;
    logic          burst_abort;
    logic          burst_timeout;

    always #5 clk = ~clk;

    rd_burst_arb #(.NUM_REQ(N), .DATA_SIZE(DW), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .rclk(clk), .rrst_n(rrst_n), .req(req), .grant(grant),
        .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .burst_done(burst_done),
        .burst_abort(burst_abort), .burst_timeout(burst_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO model
    logic [DW-1:0] fifo[$];
    bit gap       = 1'b0;
    bit auto_fill = 1'b0;
    bit pop_now   = 1'b0;

    // Arbiter model: owner index or -1, beats taken, current empty run
    bit m_ok    = 1'b0;
    int m_owner = -1;
    int m_last  = N - 1;
    int m_beats = 0;
    int m_run   = 0;
    bit m_done = 1'b0, m_abort = 1'b0, m_tmo = 1'b0;

    // Observations
    int cyc = 0;
    int tmo_cnt = 0;
    int olast_n = -1;
    int rinc_cyc[$];
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] glog[$];
    int gcyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        if (auto_fill)
            while (fifo.size() < 16) fifo.push_back(DW'($urandom));
        rempty = gap || (fifo.size() == 0);
        rdata  = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic model_step();
        logic [N-1:0] e_grant;
        bit present, e_valid, e_rinc, e_last;
        e_grant = '0; present = 0; e_valid = 0; e_rinc = 0; e_last = 0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            present = req[m_owner];
            e_valid = present && !rempty && (rrst_n === 1'b1);
            e_rinc  = e_valid && out_ready;
            e_last  = e_valid && (m_beats == BL - 1);
        end
        if (m_ok) begin
            chk("grant", grant, e_grant);
            chk("out_valid", out_valid, e_valid);
            chk("rinc", rinc, e_rinc);
            chk("out_last", out_last, e_last);
            chk("burst_done", burst_done, m_done);
            chk("burst_abort", burst_abort, m_abort);
            chk("burst_timeout", burst_timeout, m_tmo);
            chk("out_data", out_data, rdata);
            chk("rinc_needs_handshake", rinc, out_valid & out_ready);
            chk("no_pop_when_empty", rinc & rempty, 0);
        end
        cyc++;
        if (rinc === 1'b1) begin
            rinc_cyc.push_back(cyc);
            if (out_last === 1'b1) olast_n = rinc_cyc.size();
        end
        if (burst_timeout === 1'b1) tmo_cnt++;
        if (grant != '0 && prev_grant == '0) begin
            glog.push_back(grant);
            gcyc.push_back(cyc);
        end
        prev_grant = grant;
        pop_now = (rinc === 1'b1) && !rempty && (fifo.size() > 0);

        if (rrst_n !== 1'b1) begin
            m_ok = 1; m_owner = -1; m_last = N - 1; m_beats = 0; m_run = 0;
            m_done = 0; m_abort = 0; m_tmo = 0;
        end else begin
            m_done = 0; m_abort = 0; m_tmo = 0;
            if (m_owner < 0) begin
                if (req != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (req[(m_last + k) % N]) begin
                            m_owner = (m_last + k) % N;
                            break;
                        end
                    end
                    m_beats = 0;
                    m_run   = 0;
                end
            end else if (!present) begin
                m_abort = 1; m_last = m_owner; m_owner = -1;
            end else if (e_rinc && m_beats == BL - 1) begin
                m_done = 1; m_last = m_owner; m_owner = -1;
            end else if (rempty && m_run + 1 == TO) begin
                m_abort = 1; m_tmo = 1; m_last = m_owner; m_owner = -1;
            end else begin
                if (e_rinc) m_beats++;
                m_run = rempty ? m_run + 1 : 0;
            end
        end
    endtask

    // One clock cycle: settle inputs, check mid-cycle, then pop after the edge.
    task automatic tick();
        refresh();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (pop_now) void'(fifo.pop_front());
    endtask

    task automatic go_idle();
        req = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant == '0 && burst_done !== 1'b1 && burst_abort !== 1'b1) break;
        end
        tick();
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        req    = '0;
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int base;
        int span;
        int dry;
        logic [N-1:0] rr_exp [4];

        // Reset with requests pending and data available
        rrst_n = 1'b0; req = 4'b1111; out_ready = 1'b1; gap = 1'b0; auto_fill = 1'b1;
        tick();
        tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_rinc", rinc, 1'b0);
        rrst_n = 1'b1;
        tick();
        chk("rst_first_grant", grant, 4'b0001);
        go_idle();

        // Full burst from 10 stored words
        auto_fill = 1'b0;
        fifo.delete();
        for (int i = 0; i < 10; i++) fifo.push_back(DW'($urandom));
        rinc_cyc.delete();
        olast_n = -1;
        req = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (burst_done === 1'b1) break;
        end
        chk("fb_done_pulse", burst_done, 1'b1);
        chk("fb_grant_clear", grant, 4'b0000);
        chk("fb_beats", rinc_cyc.size(), 8);
        span = (rinc_cyc.size() >= 8) ? rinc_cyc[7] - rinc_cyc[0] : -1;
        chk("fb_consecutive", span, 7);
        chk("fb_last_on_8th", olast_n, 8);
        chk("fb_words_left", fifo.size(), 2);
        go_idle();

        // Round-robin from a fresh reset, FIFO always full
        do_reset();
        auto_fill = 1'b1;
        glog.delete();
        gcyc.delete();
        req = 4'b1011;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (glog.size() >= 4) break;
        end
        req = '0;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
        for (int k = 0; k < 4; k++)
            chk($sformatf("rr_grant%0d", k), (k < glog.size()) ? 32'(glog[k]) : 32'hFF, rr_exp[k]);
        for (int k = 1; k < 4; k++)
            chk($sformatf("rr_spacing%0d", k), (k < gcyc.size()) ? gcyc[k] - gcyc[k-1] : -1, 9);
        go_idle();

        // Backpressure and short empty gaps
        base = tmo_cnt;
        rinc_cyc.delete();
        req = 4'b0001;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            out_ready = i[0];
            gap = ((i % 6) >= 3);
            tick();
            cnt = i;
            if (burst_done === 1'b1) break;
        end
        chk("bp_done_pulse", burst_done, 1'b1);
        chk("bp_beats", rinc_cyc.size(), 8);
        chk("bp_no_timeout", tmo_cnt - base, 0);
        gap = 1'b0;
        out_ready = 1'b1;
        go_idle();

        // Timeout on an empty FIFO, then the next requester is served
        auto_fill = 1'b0;
        fifo.delete();
        req = 4'b0110;
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (grant == 4'b0010) cnt++;
            if (burst_timeout === 1'b1) break;
        end
        chk("to_granted_cycles", cnt, TO);
        chk("to_abort", burst_abort, 1'b1);
        chk("to_timeout", burst_timeout, 1'b1);
        tick();
        chk("to_next_grant", grant, 4'b0100);
        go_idle();

        // Request withdrawal after three beats
        auto_fill = 1'b1;
        rinc_cyc.delete();
        req = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rinc_cyc.size() >= 3) break;
        end
        req = 4'b1101;
        tick();
        chk("wd_abort", burst_abort, 1'b1);
        chk("wd_no_timeout", burst_timeout, 1'b0);
        chk("wd_beats", rinc_cyc.size(), 3);
        tick();
        chk("wd_next_grant", grant, 4'b0100);
        go_idle();

        // Randomized traffic with occasional long dry spells and resets
        auto_fill = 1'b0;
        dry = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) req = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (dry > 0) begin
                dry--;
                gap = 1'b1;
            end else begin
                gap = ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 199) == 0) dry = 70;
            end
            if ($urandom_range(0, 2) != 0 && fifo.size() < 32) fifo.push_back(DW'($urandom));
            rrst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rrst_n = 1'b1;
        go_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
